// File: rtl/dma_pkg.sv
// Shared constants and FSM state encoding for the single-channel DMA controller.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_DATA_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA: one word read then written per loop,
// with at most one request outstanding on either bus.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmaen,
  input  logic [ADDR_W-1:0] dmasrc,
  input  logic [ADDR_W-1:0] dmadst,
  input  logic [LEN_W-1:0]  dmalen,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_err,
  output logic              wr_req_valid,
  input  logic              wr_req_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_resp_valid,
  input  logic              wr_err,
  output logic              busy,
  output logic              dma_err,
  output logic              dma_interrupt
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  dma_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dmaen) begin
          state_next = (dmalen == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (rd_req_ready) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_data_valid) state_next = rd_err ? DONE : WR_REQ;
      end
      WR_REQ: begin
        if (wr_req_ready) state_next = WR_RESP;
      end
      WR_RESP: begin
        // An error response ends the transfer even with words remaining.
        if (wr_resp_valid) begin
          state_next = (wr_err || cnt_reg == LEN_W'(1)) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        if (!dmaen) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_reg  <= '0;
      dst_reg  <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dmaen) begin
            src_reg <= dmasrc;
            dst_reg <= dmadst;
            cnt_reg <= dmalen;
            err_reg <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (rd_data_valid) begin
            data_reg <= rd_data;
            if (rd_err) err_reg <= 1'b1;
          end
        end
        WR_RESP: begin
          // Addresses wrap naturally at ADDR_W bits.
          if (wr_resp_valid) begin
            src_reg <= src_reg + STRIDE;
            dst_reg <= dst_reg + STRIDE;
            cnt_reg <= cnt_reg - LEN_W'(1);
            if (wr_err) err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the state register directly, so reset clears them immediately.
  always_comb begin
    rd_req_valid  = (state_reg == RD_REQ);
    wr_req_valid  = (state_reg == WR_REQ);
    rd_addr       = src_reg;
    wr_addr       = dst_reg;
    wr_data       = data_reg;
    busy          = (state_reg != IDLE) && (state_reg != DONE);
    dma_err       = err_reg;
    dma_interrupt = (state_reg == DONE);
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: a bus responder drives the DUT, a monitor
// compares every read/write handshake against a queue of expected transactions.
module tb_dma_ctrl;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmaen = 1'b0;
  logic [31:0] dmasrc = '0;
  logic [31:0] dmadst = '0;
  logic [15:0] dmalen = '0;
  logic        rd_req_valid;
  logic        rd_req_ready = 1'b0;
  logic [31:0] rd_addr;
  logic        rd_data_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_err = 1'b0;
  logic        wr_req_valid;
  logic        wr_req_ready = 1'b0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_resp_valid = 1'b0;
  logic        wr_err = 1'b0;
  logic        busy;
  logic        dma_err;
  logic        dma_interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd_q[$];
  wr_t         wr_q[$];

  int rd_stall_cfg = 0;
  int wr_stall_cfg = 0;
  int rd_err_word  = -1;
  int wr_err_word  = -1;
  int rd_wait_cnt  = 0;
  int wr_wait_cnt  = 0;
  int rd_idx       = 0;
  int wr_idx       = 0;

  logic        rd_hold = 1'b0;
  logic [31:0] rd_hold_addr = '0;
  logic        wr_hold = 1'b0;
  wr_t         wr_hold_val = '0;

  dma_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .dmaen(dmaen),
    .dmasrc(dmasrc), .dmadst(dmadst), .dmalen(dmalen),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_resp_valid(wr_resp_valid), .wr_err(wr_err),
    .busy(busy), .dma_err(dma_err), .dma_interrupt(dma_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h0001};
  endfunction

  // Memory responder: grants each request after a configurable stall, then
  // returns data / write response exactly one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      rd_req_ready = 0; rd_data_valid = 0; rd_err = 0;
      wr_req_ready = 0; wr_resp_valid = 0; wr_err = 0;
      rd_wait_cnt = 0; wr_wait_cnt = 0; rd_idx = 0; wr_idx = 0;
    end else begin
      if (!busy) begin
        rd_idx = 0;
        wr_idx = 0;
      end
      if (rd_data_valid) begin
        rd_data_valid = 0;
        rd_err = 0;
      end else if (rd_req_ready) begin
        rd_req_ready = 0;
        rd_data_valid = 1;
        rd_data = mem_word(rd_addr);
        rd_err = (rd_idx == rd_err_word);
        rd_idx++;
      end else if (rd_req_valid) begin
        if (rd_wait_cnt < rd_stall_cfg) rd_wait_cnt++;
        else begin
          rd_req_ready = 1;
          rd_wait_cnt = 0;
        end
      end
      if (wr_resp_valid) begin
        wr_resp_valid = 0;
        wr_err = 0;
      end else if (wr_req_ready) begin
        wr_req_ready = 0;
        wr_resp_valid = 1;
        wr_err = (wr_idx == wr_err_word);
        wr_idx++;
      end else if (wr_req_valid) begin
        if (wr_wait_cnt < wr_stall_cfg) wr_wait_cnt++;
        else begin
          wr_req_ready = 1;
          wr_wait_cnt = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        rd_q.delete();
        wr_q.delete();
        rd_hold = 0;
        wr_hold = 0;
      end else begin
        if (rd_req_valid) begin
          if (rd_hold) check("rd_addr_stable", rd_addr, rd_hold_addr);
          else begin
            rd_hold = 1;
            rd_hold_addr = rd_addr;
          end
          if (rd_req_ready) begin
            rd_hold = 0;
            if (rd_q.size() == 0) check("unexpected_read", rd_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("rd_addr", rd_addr, rd_q.pop_front());
            $display("[TB] read  addr=0x%08h", rd_addr);
          end
        end
        if (wr_req_valid) begin
          if (wr_hold) check("wr_stable", {wr_addr, wr_data}, wr_hold_val);
          else begin
            wr_hold = 1;
            wr_hold_val = {wr_addr, wr_data};
          end
          if (wr_req_ready) begin
            wr_hold = 0;
            if (wr_q.size() == 0) check("unexpected_write", {wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("wr_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
            $display("[TB] write addr=0x%08h data=0x%08h", wr_addr, wr_data);
          end
        end
      end
    end
  endtask

  task automatic push_words(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [31:0] s, d;
    for (int i = 0; i < n; i++) begin
      s = src + 32'(4 * i);
      d = dst + 32'(4 * i);
      rd_q.push_back(s);
      wr_q.push_back({d, mem_word(s)});
    end
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    @(negedge clk);
    dmasrc = src;
    dmadst = dst;
    dmalen = len;
    dmaen  = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(output int cyc);
    cyc = 0;
    while (!dma_interrupt && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("irq_seen", dma_interrupt, 1);
  endtask

  task automatic end_xfer();
    @(negedge clk);
    dmaen = 0;
    @(posedge clk);
    #1;
    check("irq_cleared", dma_interrupt, 0);
    check("idle_not_busy", busy, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_reads_left"}, rd_q.size(), 0);
    check({tag, "_writes_left"}, wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_valid", rd_req_valid, 0);
    check("rst_wr_valid", wr_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", dma_err, 0);
    check("rst_irq", dma_interrupt, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check("idle_without_enable", busy, 0);

    // Basic 3-word copy at minimum latency; later input changes are ignored
    push_words(32'h1000, 32'h2000, 3);
    start_xfer(32'h1000, 32'h2000, 16'd3);
    check("busy_after_start", busy, 1);
    dmasrc = 32'hDEAD_0000;
    dmadst = 32'hBEEF_0000;
    dmalen = 16'd7;
    wait_irq(cyc);
    check("basic_irq_latency", cyc, 12);
    check("basic_no_err", dma_err, 0);
    check_drained("basic");
    @(posedge clk);
    #1;
    check("done_holds_irq", dma_interrupt, 1);
    end_xfer();

    // Zero-length transfer
    start_xfer(32'h3000, 32'h4000, 16'd0);
    check("len0_irq", dma_interrupt, 1);
    check("len0_busy", busy, 0);
    check("len0_no_read", rd_req_valid, 0);
    end_xfer();

    // Stalled handshakes: read grant 5 cycles late, write grant 3 cycles late
    rd_stall_cfg = 5;
    wr_stall_cfg = 3;
    push_words(32'h0100, 32'h8000, 2);
    start_xfer(32'h0100, 32'h8000, 16'd2);
    wait_irq(cyc);
    check("stall_irq_latency", cyc, 24);
    check_drained("stall");
    end_xfer();
    rd_stall_cfg = 0;
    wr_stall_cfg = 0;

    // Read error on the second word: one write only
    rd_err_word = 1;
    rd_q.push_back(32'h5000);
    rd_q.push_back(32'h5004);
    wr_q.push_back({32'h6000, mem_word(32'h5000)});
    start_xfer(32'h5000, 32'h6000, 16'd4);
    wait_irq(cyc);
    check("rderr_latency", cyc, 6);
    check("rderr_flag", dma_err, 1);
    check_drained("rderr");
    end_xfer();
    check("err_held_in_idle", dma_err, 1);
    rd_err_word = -1;
    push_words(32'h7000, 32'h7100, 1);
    start_xfer(32'h7000, 32'h7100, 16'd1);
    check("err_cleared_on_start", dma_err, 0);
    wait_irq(cyc);
    check("after_err_latency", cyc, 4);
    check_drained("after_err");
    end_xfer();

    // Write error on the first word ends the transfer early
    wr_err_word = 0;
    push_words(32'h0200, 32'h0300, 1);
    start_xfer(32'h0200, 32'h0300, 16'd3);
    wait_irq(cyc);
    check("wrerr_latency", cyc, 4);
    check("wrerr_flag", dma_err, 1);
    check_drained("wrerr");
    end_xfer();
    wr_err_word = -1;

    // Source address wraps past the top of the address space
    push_words(32'hFFFF_FFFC, 32'h0000_0010, 2);
    start_xfer(32'hFFFF_FFFC, 32'h0000_0010, 16'd2);
    wait_irq(cyc);
    check("wrap_latency", cyc, 8);
    check_drained("wrap");
    end_xfer();

    // Asynchronous reset while a write request is pending
    wr_stall_cfg = 10;
    push_words(32'h9000, 32'hA000, 2);
    start_xfer(32'h9000, 32'hA000, 16'd2);
    k = 0;
    while (!wr_req_valid && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reached_wr_req", wr_req_valid, 1);
    #2;
    rst = 1;
    #1;
    check("arst_wr_valid", wr_req_valid, 0);
    check("arst_rd_valid", rd_req_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_err", dma_err, 0);
    check("arst_irq", dma_interrupt, 0);
    check("arst_regs", {wr_addr, wr_data}, 64'h0);
    check("arst_rd_addr", rd_addr, 0);
    wr_stall_cfg = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    dmasrc = 32'hB000;
    dmadst = 32'hC000;
    dmalen = 16'd2;
    dmaen  = 1;
    push_words(32'hB000, 32'hC000, 2);
    @(posedge clk);
    #1;
    check("start_after_reset", busy, 1);
    wait_irq(cyc);
    check("post_reset_latency", cyc, 8);
    check("post_reset_no_err", dma_err, 0);
    check_drained("post_reset");
    end_xfer();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: word width; address stride is DATA_W/8 bytes.
REQ-003 SHALL have parameter LEN_W, default 16: width of the transfer length in words.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port dmaen, input, 1: enable; while held high in IDLE, a transfer starts.
REQ-007 SHALL have port dmasrc, input, ADDR_W: source start address, word-aligned.
REQ-008 SHALL have port dmadst, input, ADDR_W: destination start address, word-aligned.
REQ-009 SHALL have port dmalen, input, LEN_W: number of words to copy.
REQ-010 SHALL have ports rd_req_valid (out, 1), rd_req_ready (in, 1) and rd_addr (out, ADDR_W): read-address handshake.
REQ-011 SHALL have ports rd_data_valid (in, 1), rd_data (in, DATA_W) and rd_err (in, 1): read data return; the controller is always ready for it.
REQ-012 SHALL have ports wr_req_valid (out, 1), wr_req_ready (in, 1), wr_addr (out, ADDR_W) and wr_data (out, DATA_W): write handshake carrying address and data together.
REQ-013 SHALL have ports wr_resp_valid (in, 1) and wr_err (in, 1): write response.
REQ-014 SHALL have ports busy (out, 1), dma_err (out, 1) and dma_interrupt (out, 1): status outputs.

Function
REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_RESP and DONE.
REQ-016 SHALL, in IDLE with dmaen=1, latch dmasrc, dmadst and dmalen into internal registers, clear dma_err and go to RD_REQ; if dmalen=0, it SHALL go directly to DONE.
REQ-017 SHALL assert rd_req_valid with rd_addr equal to the current source address throughout RD_REQ, and hold both stable until rd_req_ready; the handshake cycle moves the FSM to RD_WAIT.
REQ-018 SHALL, in RD_WAIT on rd_data_valid=1, capture rd_data into the data register and go to WR_REQ; if rd_err=1 it SHALL set dma_err and go to DONE without writing.
REQ-019 SHALL assert wr_req_valid with wr_addr equal to the current destination address and wr_data equal to the data register throughout WR_REQ, hold all three stable until wr_req_ready, then go to WR_RESP.
REQ-020 SHALL, in WR_RESP on wr_resp_valid=1, do the following in the same edge: increment the source and destination addresses by DATA_W/8, and decrement the remaining count.
REQ-021 SHALL then go to DONE if the remaining count was 1; otherwise it SHALL go to RD_REQ.
REQ-022 SHALL, if wr_err=1 with wr_resp_valid, set dma_err and go to DONE regardless of the remaining count.
REQ-023 SHALL wrap address arithmetic modulo 2^ADDR_W.
REQ-024 SHALL keep at most one read or write request outstanding; a minimum-latency word takes 4 cycles (RD_REQ, RD_WAIT, WR_REQ, WR_RESP).
REQ-025 SHALL, in DONE, hold dma_interrupt=1 and stay there until dmaen=0; it SHALL then go to IDLE, clearing dma_interrupt on that edge.
REQ-026 SHALL hold dma_err until the next transfer start.
REQ-027 SHALL drive busy=1 in every state except IDLE and DONE.
REQ-028 SHALL ignore changes on dmasrc, dmadst and dmalen after the latch, and SHALL not abort on dmaen=0 before DONE.
REQ-029 SHALL ignore rd_data_valid outside RD_WAIT and wr_resp_valid outside WR_RESP.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-transfer, force IDLE; set rd_req_valid, wr_req_valid, busy, dma_err and dma_interrupt to 0; and clear the address, count and data registers to 0.
REQ-031 SHALL allow a new start on the first clk edge after rst deasserts if dmaen=1.

Structure
REQ-032 SHALL place the FSM state enum and the default ADDR_W, DATA_W and LEN_W constants in shared package dma_pkg.
REQ-033 SHALL be a single module with no sub-modules; the counter and address registers are inline.

Verification
REQ-034 SHALL pass this test: src=0x1000, dst=0x2000, len=3, ready/valid return the next cycle -> reads at 0x1000/0x1004/0x1008, writes carry matching data to 0x2000/0x2004/0x2008, dma_interrupt rises 12 cycles after the start edge.
REQ-035 SHALL pass this test: len=0 with dmaen=1 -> no rd_req_valid, DONE and dma_interrupt=1 the cycle after start; dmaen=0 clears dma_interrupt.
REQ-036 SHALL pass this test: rd_req_ready held low 5 cycles, then wr_req_ready held low 3 cycles -> valid, address and data stay constant throughout; transfer completes correctly.
REQ-037 SHALL pass this test: len=4, rd_err on word 2 -> dma_err=1, only 1 write issued, dma_interrupt=1, next start clears dma_err.
REQ-038 SHALL pass this test: src=0xFFFF_FFFC, len=2 -> second read at 0x0000_0000.
REQ-039 SHALL pass this test: rst pulsed while in WR_REQ -> all outputs 0 asynchronously; a new transfer after reset runs cleanly.
